div_iter: RTL and testbench

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter_pkg.sv | 6 +
 rtl/div_iter.sv | 100 ++++++++++
 tb/tb_div_iter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state enum, default operand width and divide-by-zero quotient
package div_iter_pkg;
  localparam int DIV_W = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
endpackage

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, signed/unsigned, one quotient bit per cycle, cancelable
module div_iter
  import div_iter_pkg::div_state_e, div_iter_pkg::IDLE, div_iter_pkg::BUSY, div_iter_pkg::DONE, div_iter_pkg::DIV_ZERO_Q;
#(
  parameter int DIV_W = div_iter_pkg::DIV_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_signed,
  input  logic               cancel,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  input  logic [DIV_W-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [DIV_W-1:0]   s_axis_dividend_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [2*DIV_W-1:0] m_axis_dout_tdata
);
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [DIV_W-1:0] ZERO_Q = DIV_W'($signed(DIV_ZERO_Q));
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] x, input logic s);
    return (s && x[DIV_W-1]) ? -x : x;
  endfunction
  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic [2*DIV_W-1:0] dout_q, dout_d;
  logic [DIV_W:0] rem_sh, sub;
  logic ge, accept, last;
  logic [DIV_W-1:0] rem_nx, quo_nx;
  assign rem_sh = {rem_q, quo_q[DIV_W-1]};
  assign sub = rem_sh - {1'b0, dvs_q};
  assign ge = rem_sh >= {1'b0, dvs_q};
  assign rem_nx = ge ? DIV_W'(sub) : DIV_W'(rem_sh);
  assign quo_nx = {quo_q[DIV_W-2:0], ge};
  assign accept = s_axis_dividend_tvalid && s_axis_divisor_tvalid && !cancel;
  assign last = cnt_q == CNT_W'(DIV_W - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    dout_d = dout_q;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = BUSY;
        cnt_d = '0;
        rem_d = '0;
        quo_d = mag(s_axis_dividend_tdata, div_signed);
        dvs_d = mag(s_axis_divisor_tdata, div_signed);
        qneg_d = div_signed && (s_axis_dividend_tdata[DIV_W-1] ^ s_axis_divisor_tdata[DIV_W-1]);
        rneg_d = div_signed && s_axis_dividend_tdata[DIV_W-1];
      end
    end else if (state_q == BUSY) begin
      if (cancel) begin
        state_d = IDLE;
      end else begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          state_d = DONE;
          dout_d = {(dvs_q == '0) ? ZERO_Q : (qneg_q ? -quo_nx : quo_nx), rneg_q ? -rem_nx : rem_nx};
        end
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dout_q <= dout_d;
    end
  end
  assign s_axis_divisor_tready = state_q == IDLE;
  assign s_axis_dividend_tready = state_q == IDLE;
  assign m_axis_dout_tvalid = state_q == DONE;
  assign m_axis_dout_tdata = dout_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter covering latency, signs, div-by-zero, cancel and reset
module tb_div_iter;
  localparam int W = 32;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic div_signed = 1'b0;
  logic cancel = 1'b0;
  logic dv_valid = 1'b0;
  logic dd_valid = 1'b0;
  logic [W-1:0] dv_data = '0;
  logic [W-1:0] dd_data = '0;
  logic dv_ready, dd_ready, dout_valid;
  logic [2*W-1:0] dout;
  logic [2*W-1:0] last_res = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    logic [2*W-1:0] data;
    int at;
  } exp_t;
  exp_t sb[$];
  div_iter #(.DIV_W(W)) dut (
    .clk(clk),
    .resetn(resetn),
    .div_signed(div_signed),
    .cancel(cancel),
    .s_axis_divisor_tvalid(dv_valid),
    .s_axis_divisor_tready(dv_ready),
    .s_axis_divisor_tdata(dv_data),
    .s_axis_dividend_tvalid(dd_valid),
    .s_axis_dividend_tready(dd_ready),
    .s_axis_dividend_tdata(dd_data),
    .m_axis_dout_tvalid(dout_valid),
    .m_axis_dout_tdata(dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (resetn && dout_valid) begin
      if (sb.size() == 0) chk("spurious_tvalid", 64'(dout_valid), 64'(0));
      else begin
        e = sb.pop_front();
        chk("tdata", dout, e.data);
        chk("latency", 64'(cyc), 64'(e.at));
        last_res = e.data;
      end
    end
  end
  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg, input logic [2*W-1:0] e, input bit push);
    dd_data = dd;
    dv_data = dv;
    div_signed = sg;
    dd_valid = 1'b1;
    dv_valid = 1'b1;
    chk("tready_idle", 64'({dd_ready, dv_ready}), 64'(2'b11));
    if (push) sb.push_back('{e, cyc + 33});
    @(posedge clk);
    @(negedge clk);
    dd_valid = 1'b0;
    dv_valid = 1'b0;
    dd_data = $urandom;
    dv_data = $urandom;
    div_signed = ~sg;
    chk("tready_busy", 64'({dd_ready, dv_ready}), 64'(0));
  endtask
  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
    chk("hold", dout, last_res);
  endtask
  initial begin
    logic [W-1:0] a, b;
    logic s;
    repeat (2) @(negedge clk);
    chk("rst_tready", 64'({dd_ready, dv_ready}), 64'(2'b11));
    chk("rst_tvalid", 64'(dout_valid), 64'(0));
    chk("rst_tdata", dout, 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0, {32'h0000_000E, 32'h0000_0002}, 1'b1);
    wait_done();
    do_div(-32'sd7, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b1);
    wait_done();
    do_div(32'd7, -32'sd2, 1'b1, {32'hFFFF_FFFD, 32'h0000_0001}, 1'b1);
    wait_done();
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0}, 1'b1);
    wait_done();
    do_div(32'h1234_5678, 32'h0, 1'b0, {32'hFFFF_FFFF, 32'h1234_5678}, 1'b1);
    wait_done();
    do_div(-32'sd5, 32'h0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1'b1);
    wait_done();
    do_div(32'hFFFF_FFF0, 32'd3, 1'b0, {32'h5555_5550, 32'h0}, 1'b1);
    wait_done();
    dd_valid = 1'b1;
    dd_data = 32'd50;
    dv_data = 32'd5;
    repeat (5) begin
      @(negedge clk);
      chk("single_valid_tready", 64'({dd_ready, dv_ready}), 64'(2'b11));
    end
    do_div(32'd50, 32'd5, 1'b0, {32'd10, 32'd0}, 1'b1);
    wait_done();
    dd_valid = 1'b1;
    dv_valid = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    chk("idle_cancel_blocks", 64'({dd_ready, dv_ready}), 64'(2'b11));
    cancel = 1'b0;
    dd_valid = 1'b0;
    dv_valid = 1'b0;
    do_div(32'd1000, 32'd3, 1'b0, '0, 1'b0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("busy_cancel_tready", 64'({dd_ready, dv_ready}), 64'(2'b11));
    do_div(32'd9, 32'd3, 1'b0, {32'd3, 32'd0}, 1'b1);
    wait_done();
    do_div(32'd45, 32'd6, 1'b0, {32'd7, 32'd3}, 1'b1);
    repeat (32) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("done_cancel_tready", 64'({dd_ready, dv_ready}), 64'(2'b11));
    chk("done_cancel_result", 64'(sb.size()), 64'(0));
    do_div(32'd77, 32'd7, 1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_tready", 64'({dd_ready, dv_ready}), 64'(2'b11));
    chk("async_rst_tvalid", 64'(dout_valid), 64'(0));
    chk("async_rst_tdata", dout, 64'(0));
    last_res = '0;
    @(negedge clk);
    resetn = 1'b1;
    do_div(32'd1001, 32'd10, 1'b0, {32'd100, 32'd1}, 1'b1);
    wait_done();
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
      if (i % 4 == 1) b = -W'($urandom_range(1, 9));
      s = 1'($urandom_range(0, 1));
      do_div(a, b, s, model(a, b, s), 1'b1);
      wait_done();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
